// File: rtl/pdp1_pkg.sv
// Shared constants and types for the PDP-1 paper-tape RIM loader.
package pdp1_pkg;

    localparam int unsigned FRAME_W = 6;

    localparam logic [FRAME_W-1:0] OP_DIO = 6'o32;
    localparam logic [FRAME_W-1:0] OP_JMP = 6'o60;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_OPCODE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_CMD,
        ST_GET_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } rim_state_e;

endpackage

// File: rtl/pdp1_rim_word_assembler.sv
// Packs three 6-bit tape frames into one 18-bit word; blank (no data-hole) bytes are dropped.
module pdp1_rim_word_assembler
    import pdp1_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 accept,
    input  logic                 data_hole,
    input  logic [FRAME_W-1:0]   frame,
    output logic [1:0]           frame_count,
    output logic                 word_valid_c,
    output logic [3*FRAME_W-1:0] word_next_c
);

    // Only the two older frames need storage; the third completes the word in flight.
    logic [2*FRAME_W-1:0] word_q;
    logic                 shift_c;

    assign shift_c      = accept && data_hole;
    assign word_next_c  = {word_q, frame};
    assign word_valid_c = shift_c && (frame_count == 2'd2);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            word_q      <= '0;
            frame_count <= 2'd0;
        end else if (clear) begin
            word_q      <= '0;
            frame_count <= 2'd0;
        end else if (shift_c) begin
            word_q      <= word_next_c[2*FRAME_W-1:0];
            frame_count <= (frame_count == 2'd2) ? 2'd0 : frame_count + 2'd1;
        end
    end

endmodule

// File: rtl/pdp1_rim_loader.sv
// RIM paper-tape loader: decodes DIO address/data word pairs into port-B RAM writes, stops on JMP.
module pdp1_rim_loader
    import pdp1_pkg::*;
#(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned WORD_W         = 18,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        tape_data,
    input  logic              tape_valid,
    output logic              tape_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [WORD_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        error_code,
    output logic [ADDR_W-1:0] start_address,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned IDLE_W = 32;

    rim_state_e          state, state_next;
    logic                accept_c;
    logic                in_get_c;
    logic                timeout_c;
    logic [1:0]          frame_count;
    logic                word_valid_c;
    logic [3*FRAME_W-1:0] word_next_c;
    logic [IDLE_W-1:0]   idle_q;
    logic                latch_addr_c;
    logic                latch_data_c;
    logic                set_done_c;
    logic                set_err_c;
    logic [1:0]          err_code_c;
    logic                unused_tape_bit6;

    assign unused_tape_bit6 = tape_data[6];
    assign accept_c  = tape_valid && tape_ready;
    assign in_get_c  = (state == ST_GET_CMD) || (state == ST_GET_DATA);
    assign timeout_c = (TIMEOUT_CYCLES != 0) && in_get_c && (frame_count != 2'd0) &&
                       !accept_c && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

    pdp1_rim_word_assembler u_assembler (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (start),
        .accept       (accept_c),
        .data_hole    (tape_data[7]),
        .frame        (tape_data[FRAME_W-1:0]),
        .frame_count  (frame_count),
        .word_valid_c (word_valid_c),
        .word_next_c  (word_next_c)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and one-cycle control strobes.
    always_comb begin
        state_next   = state;
        latch_addr_c = 1'b0;
        latch_data_c = 1'b0;
        set_done_c   = 1'b0;
        set_err_c    = 1'b0;
        err_code_c   = ERR_NONE;
        if (start) begin
            state_next = ST_GET_CMD;
        end else begin
            case (state)
                ST_GET_CMD: begin
                    if (timeout_c) begin
                        set_err_c  = 1'b1;
                        err_code_c = ERR_TIMEOUT;
                        state_next = ST_ERROR;
                    end else if (word_valid_c) begin
                        if (word_next_c[17:12] == OP_DIO) begin
                            latch_addr_c = 1'b1;
                            state_next   = ST_GET_DATA;
                        end else if (word_next_c[17:12] == OP_JMP) begin
                            set_done_c = 1'b1;
                            state_next = ST_DONE;
                        end else begin
                            set_err_c  = 1'b1;
                            err_code_c = ERR_OPCODE;
                            state_next = ST_ERROR;
                        end
                    end
                end
                ST_GET_DATA: begin
                    if (timeout_c) begin
                        set_err_c  = 1'b1;
                        err_code_c = ERR_TIMEOUT;
                        state_next = ST_ERROR;
                    end else if (word_valid_c) begin
                        latch_data_c = 1'b1;
                        state_next   = ST_WRITE;
                    end
                end
                ST_WRITE: state_next = ST_GET_CMD;
                default:  state_next = state;
            endcase
        end
    end

    // Registered outputs, derived from the next state so they line up with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tape_ready    <= 1'b0;
            busy          <= 1'b0;
            ram_wren      <= 1'b0;
            ram_address   <= '0;
            ram_data      <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            error_code    <= ERR_NONE;
            start_address <= '0;
            words_loaded  <= '0;
            idle_q        <= '0;
        end else begin
            tape_ready <= (state_next == ST_GET_CMD) || (state_next == ST_GET_DATA);
            busy       <= (state_next == ST_GET_CMD) || (state_next == ST_GET_DATA) ||
                          (state_next == ST_WRITE);
            ram_wren   <= (state_next == ST_WRITE);
            if (latch_addr_c) begin
                ram_address <= ADDR_W'(word_next_c[11:0]);
            end
            if (latch_data_c) begin
                ram_data <= WORD_W'(word_next_c);
            end
            if (set_done_c) begin
                start_address <= ADDR_W'(word_next_c[11:0]);
            end
            if (start) begin
                done         <= 1'b0;
                error        <= 1'b0;
                error_code   <= ERR_NONE;
                words_loaded <= '0;
            end else begin
                if (set_done_c) begin
                    done <= 1'b1;
                end
                if (set_err_c) begin
                    error      <= 1'b1;
                    error_code <= err_code_c;
                end
                // Top bit set means the count has reached 2**ADDR_W and saturates.
                if ((state == ST_WRITE) && !words_loaded[ADDR_W]) begin
                    words_loaded <= words_loaded + 1'b1;
                end
            end
            if (start || accept_c || !in_get_c || (frame_count == 2'd0)) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pdp1_rim_loader.sv
// Directed bench for the RIM loader: table of word pairs plus hand-written corner sequences.
module tb_pdp1_rim_loader;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [7:0]  tape_data;
    logic        tape_valid;
    logic        tape_ready;
    logic [11:0] ram_address;
    logic [17:0] ram_data;
    logic        ram_wren;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  error_code;
    logic [11:0] start_address;
    logic [12:0] words_loaded;

    int checks = 0;
    int errors = 0;
    int bp_viol = 0;

    logic [11:0] cap_addr[$];
    logic [17:0] cap_data[$];

    typedef struct {
        logic [23:0] cmd_bytes;
        logic [23:0] data_bytes;
        logic [11:0] exp_addr;
        logic [17:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    pdp1_rim_loader #(
        .ADDR_W         (12),
        .WORD_W         (18),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .tape_data     (tape_data),
        .tape_valid    (tape_valid),
        .tape_ready    (tape_ready),
        .ram_address   (ram_address),
        .ram_data      (ram_data),
        .ram_wren      (ram_wren),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .error_code    (error_code),
        .start_address (start_address),
        .words_loaded  (words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every RAM write and flag any cycle where tape_ready is not exactly "busy and not writing".
    always @(negedge clock) begin
        if (ram_wren) begin
            cap_addr.push_back(ram_address);
            cap_data.push_back(ram_data);
        end
        if (reset_n && busy && (tape_ready != !ram_wren)) bp_viol++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        tape_data  = b;
        tape_valid = 1'b1;
        while (!tape_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!tape_ready) begin
            checks++;
            errors++;
            $display("FAIL send_byte: tape_ready got 0 for 40 cycles, want 1 (byte %0h)", b);
        end else begin
            @(negedge clock);
        end
    endtask

    task automatic send3(input logic [23:0] b);
        send_byte(b[23:16]);
        send_byte(b[15:8]);
        send_byte(b[7:0]);
    endtask

    task automatic pulse_start();
        tape_valid = 1'b0;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic clear_capture();
        cap_addr.delete();
        cap_data.delete();
    endtask

    initial begin
        vecs[0] = '{24'h9A8180, 24'h8A9CAE, 12'o0100, 18'o123456};
        vecs[1] = '{24'h9ABFBF, 24'hBFBFBF, 12'o7777, 18'o777777};
        vecs[2] = '{24'h9A8080, 24'h808080, 12'o0000, 18'o000000};
        vecs[3] = '{24'h9A85A7, 24'h8192A3, 12'o0547, 18'o012243};
        vecs[4] = '{24'h9A8180, 24'hB5A391, 12'o0100, 18'o654321};

        reset_n    = 1'b0;
        start      = 1'b0;
        tape_data  = 8'h00;
        tape_valid = 1'b0;
        #2;
        check("reset tape_ready", 32'(tape_ready), 0);
        check("reset busy", 32'(busy), 0);
        check("reset ram_wren", 32'(ram_wren), 0);
        check("reset done/error", 32'({done, error, error_code}), 0);
        check("reset words_loaded", 32'(words_loaded), 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Single pair: DIO 0o100, data 0o123456, JMP 0o100
        clear_capture();
        pulse_start();
        check("start busy", 32'(busy), 1);
        check("start tape_ready", 32'(tape_ready), 1);
        send3(24'h9A8180);
        send3(24'h8A9CAE);
        send3(24'hB08180);
        tape_valid = 1'b0;
        @(negedge clock);
        check("single wren count", 32'(cap_addr.size()), 1);
        if (cap_addr.size() == 1) begin
            check("single addr", 32'(cap_addr[0]), 32'o0100);
            check("single data", 32'(cap_data[0]), 32'o123456);
        end
        check("single done", 32'(done), 1);
        check("single start_address", 32'(start_address), 32'o0100);
        check("single words_loaded", 32'(words_loaded), 1);
        check("single busy", 32'(busy), 0);

        // Leader and interleaved blanks
        clear_capture();
        pulse_start();
        for (int i = 0; i < 20; i++) send_byte(8'h00);
        send_byte(8'h9A); send_byte(8'h00); send_byte(8'h81); send_byte(8'h00); send_byte(8'h80);
        send_byte(8'h8A); send_byte(8'h00); send_byte(8'h9C); send_byte(8'hAE); send_byte(8'h00);
        send_byte(8'hB0); send_byte(8'h81); send_byte(8'h80);
        tape_valid = 1'b0;
        @(negedge clock);
        check("leader wren count", 32'(cap_addr.size()), 1);
        if (cap_addr.size() == 1) begin
            check("leader addr", 32'(cap_addr[0]), 32'o0100);
            check("leader data", 32'(cap_data[0]), 32'o123456);
        end
        check("leader done", 32'(done), 1);
        check("leader start_address", 32'(start_address), 32'o0100);
        check("leader words_loaded", 32'(words_loaded), 1);

        // Table of pairs in one tape, valid held high throughout
        clear_capture();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send3(vecs[i].cmd_bytes);
            send3(vecs[i].data_bytes);
        end
        send3(24'hB0BF80);
        tape_valid = 1'b0;
        @(negedge clock);
        check("table wren count", 32'(cap_addr.size()), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < cap_addr.size()) begin
                check($sformatf("table[%0d] addr", i), 32'(cap_addr[i]), 32'(vecs[i].exp_addr));
                check($sformatf("table[%0d] data", i), 32'(cap_data[i]), 32'(vecs[i].exp_data));
            end
        end
        check("table words_loaded", 32'(words_loaded), 5);
        check("table start_address", 32'(start_address), 32'o7700);
        check("table done/error", 32'({done, error}), 32'b10);
        check("table tape_ready", 32'(tape_ready), 0);
        check("backpressure tape_ready vs write", 32'(bp_viol), 0);

        // Bad opcode 0o40
        clear_capture();
        pulse_start();
        check("restart clears done", 32'(done), 0);
        send3(24'hA08080);
        tape_valid = 1'b0;
        @(negedge clock);
        check("badop error", 32'(error), 1);
        check("badop error_code", 32'(error_code), 1);
        check("badop tape_ready", 32'(tape_ready), 0);
        check("badop busy", 32'(busy), 0);
        check("badop wren count", 32'(cap_addr.size()), 0);

        // Frame timeout: 15 idle cycles tolerated, 16th aborts
        pulse_start();
        check("start clears error", 32'({error, error_code}), 0);
        send_byte(8'h9A);
        tape_valid = 1'b0;
        repeat (15) @(negedge clock);
        check("timeout not yet", 32'(error), 0);
        @(negedge clock);
        check("timeout error", 32'(error), 1);
        check("timeout error_code", 32'(error_code), 2);
        check("timeout busy", 32'(busy), 0);

        // Restart mid data word
        clear_capture();
        pulse_start();
        send3(24'h9A8180);
        send3(24'h8A9CAE);
        send3(24'h9A8180);
        send_byte(8'h8A);
        tape_valid = 1'b0;
        @(negedge clock);
        check("pre-restart words_loaded", 32'(words_loaded), 1);
        pulse_start();
        check("restart words_loaded", 32'(words_loaded), 0);
        check("restart busy", 32'(busy), 1);
        clear_capture();
        send3(vecs[3].cmd_bytes);
        send3(vecs[3].data_bytes);
        send3(24'hB08180);
        tape_valid = 1'b0;
        @(negedge clock);
        check("restart wren count", 32'(cap_addr.size()), 1);
        if (cap_addr.size() == 1) begin
            check("restart addr", 32'(cap_addr[0]), 32'o0547);
            check("restart data", 32'(cap_data[0]), 32'o012243);
        end
        check("restart words_loaded final", 32'(words_loaded), 1);
        check("restart done", 32'(done), 1);

        // Asynchronous reset during the WRITE cycle
        pulse_start();
        send3(24'h9A8180);
        send3(24'h8A9CAE);
        tape_valid = 1'b0;
        check("mid-write wren", 32'(ram_wren), 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async reset wren", 32'(ram_wren), 0);
        check("async reset busy/ready", 32'({busy, tape_ready}), 0);
        check("async reset address", 32'(ram_address), 0);
        check("async reset data", 32'(ram_data), 0);
        check("async reset words_loaded", 32'(words_loaded), 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post reset idle", 32'({busy, done, error}), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdp1_rim_loader.md
Name: pdp1_rim_loader

Overview:
Paper-tape RIM (Read-In Mode) loader that sits directly upstream of pdp1_main_ram and drives its port B (address_b/data_b/wren_b). It accepts a tape byte stream over a valid/ready handshake and assembles three 6-bit frames into each 18-bit word. It decodes DIO-address/data word pairs into RAM writes and stops on the terminating JMP word, reporting the program start address to the CPU reset/start logic.

Parameters:
ADDR_W, 12, RAM address width (4096 words)
WORD_W, 18, PDP-1 word width
TIMEOUT_CYCLES, 0, max idle cycles between frames of one word; 0 disables the timeout

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: clear status, begin (or restart) a load
tape_data  in  8  tape byte; bit7 = data-hole flag, bits5:0 = frame
tape_valid  in  1  tape_data valid
tape_ready  out  1  loader accepts a byte this cycle
ram_address  out  ADDR_W  to address_b
ram_data  out  WORD_W  to data_b
ram_wren  out  1  to wren_b, one-cycle pulse per data word
busy  out  1  load in progress
done  out  1  sticky: JMP word received
error  out  1  sticky: load aborted
error_code  out  2  1 = bad opcode, 2 = frame timeout, 0 = none
start_address  out  ADDR_W  JMP target, valid while done=1
words_loaded  out  ADDR_W+1  count of RAM writes this load

Behaviour:
- Reset: every output 0; state IDLE; word assembler and frame counter cleared.
- States: IDLE, GET_CMD, GET_DATA, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR: tape_ready=0. On start, clear done, error, error_code, words_loaded, assembler and frame count, then go to GET_CMD. start in any other state restarts the load the same way (abort mid-load).
- GET_CMD/GET_DATA: tape_ready=1. A byte transfers when tape_valid && tape_ready. A byte with bit7=0 (leader/blank) is consumed and ignored. A byte with bit7=1 shifts the word: word <= {word[11:0], tape_data[5:0]}, frame count increments (0..2).
- Third frame completes a word, and the frame count returns to 0:
  - In GET_CMD, with opcode = word[17:12]:
    - 6'o32 (DIO): latch word[11:0] as the target address, go to GET_DATA.
    - 6'o60 (JMP): start_address <= word[11:0], done <= 1, go to DONE.
    - Anything else: error <= 1, error_code <= 1, go to ERROR.
  - In GET_DATA: latch the word into ram_data, go to WRITE.
- WRITE, exactly one cycle: tape_ready=0, ram_wren=1, ram_address = latched address, words_loaded increments (saturates at 4096), then go to GET_CMD.
- Latency: ram_wren is asserted in the cycle after the third data frame is accepted. Total per word pair: 6 accepted frames + 1 cycle.
- Address wrap: not applicable; each write uses the explicit DIO address. Writes to the same address repeat, and the last one wins.
- Timeout (TIMEOUT_CYCLES>0): the idle counter runs only while frame count is 1 or 2. It resets on every accepted byte, including blanks. On reaching TIMEOUT_CYCLES: error=1, error_code=2, go to ERROR. No timeout applies between words.
- ram_wren is never asserted outside WRITE. The CPU must not write port B while busy.
- busy = 1 in GET_CMD, GET_DATA and WRITE.
- Asynchronous reset mid-WRITE: wren drops immediately and no partial state is retained.

Decomposition:
- Package pdp1_pkg holds:
  - opcode constants OP_DIO=6'o32 and OP_JMP=6'o60
  - the state enum
  - error code constants ERR_NONE, ERR_OPCODE, ERR_TIMEOUT
- One sub-module, pdp1_rim_word_assembler: frame shift register, frame counter, blank filtering, and a word_valid pulse on the third frame.

Test Plan:
- Single pair: start; bytes 9A 81 80 8A 9C AE B0 81 80 (DIO 0o100, data 0o123456, JMP 0o100) -> one ram_wren at address 0o100 with data 0o123456; done=1; start_address=0o100; words_loaded=1; busy=0.
- Leader: 20 bytes of 0x00 before, and 0x00 interleaved inside a word, -> ignored; same result as the single-pair case.
- Bad opcode: frames 0o40, 0o00, 0o00 -> error=1, error_code=1, no wren, tape_ready=0.
- Backpressure: tape_valid held high throughout -> tape_ready low exactly during the WRITE cycle; no byte lost or duplicated.
- Timeout (TIMEOUT_CYCLES=16): one data frame, then 16 idle cycles -> error_code=2.
- Restart: start pulse mid-data-word -> counters cleared; a subsequent full tape loads correctly with words_loaded counting from 0.
- Reset: assert reset_n mid-load -> all outputs 0 immediately.
